cnn_obi_spm: RTL and testbench
==============================

// Module: cnn_obi_spm
// PURPOSE
//  OBI subordinate scratchpad that answers the CNN accelerator's manager port.
//  It serves input-pixel reads and pooled-result writes at the Croc window 0x1A10_0000.
//  Response latency is fixed and parameterised. Optional periodic grant stalls exercise
//  manager back-pressure. A clear sweep zeroes the array between inference runs.
// PARAMETERS
//  ObiCfg        obi_pkg::ObiDefaultConfig  OBI config (AddrWidth/DataWidth 32, IdWidth)
//  BASE_ADDR     32'h1A10_0000              byte address of word 0
//  NUM_WORDS     256                        32-bit words in array (power of 2, >=4)
//  LATENCY       1                          handshake-to-rvalid cycles (1..4)
//  STALL_PERIOD  0                          0 = never stall; N>0 = 1 forced gnt=0 per N req cycles
// PORTS
//  clk_i           in   1       clock
//  rst_ni          in   1       async active-low reset
//  sbr_obi_req_i   in   obi_req_t  request from accelerator manager (req, a.addr/we/be/wdata/aid)
//  sbr_obi_rsp_o   out  obi_rsp_t  gnt, rvalid, r.rdata/rid/err; r_optional tied '0
//  clear_i         in   1       1-cycle pulse: start zeroing sweep
//  busy_o          out  1       1 while sweep in progress
//  rd_cnt_o        out  16      in-range reads accepted, saturating
//  wr_cnt_o        out  16      in-range writes accepted, saturating
// BEHAVIOUR
//  Reset: gnt=0, rvalid=0, rdata=0, rid=0, err=0, busy_o=0, counters=0.
//   Reset clears stall counter and pipeline. Array contents are not reset.
//  Decode: off = addr - BASE_ADDR; in_range = addr>=BASE_ADDR && off < NUM_WORDS*4.
//   idx = off[log2(NUM_WORDS)+1:2]. addr[1:0] is ignored.
//  Stall counter: counts cycles with req=1 in IDLE (modulo STALL_PERIOD). It holds while
//   req=0. On the cycle it equals STALL_PERIOD-1, gnt=0 and the counter wraps to 0.
//  gnt (combinational) = req && state==IDLE && !stall. Handshake (hs) = req && gnt.
//  Write hs, in range: mem[idx] byte i <= wdata byte i for each be[i]=1. Response is
//   rdata=0, err=0. be=0 is legal: no bytes change, still responds.
//  Read hs, in range: response rdata = mem[idx] as seen at the hs clock edge.
//   A write hs in cycle t is visible to a read hs in cycle t+1.
//  Out of range (either direction): no array access, counters unchanged, err=1.
//   rdata = 32'hDEAD_BEEF for reads and 0 for writes.
//  Response pipe: LATENCY stages of {valid,rid,rdata,err}. Stage 0 loads on hs;
//   stages always shift. rvalid is high exactly LATENCY cycles after the hs cycle.
//   rid = aid of that request. One request per cycle is sustained with in-order responses.
//   No rready: responses can never be stalled. Non-valid stages drive rdata/rid/err as 0.
//  Counters: +1 on in-range read or write hs. They saturate at 16'hFFFF and never wrap.
//  FSM IDLE/CLEAR:
//   IDLE -> CLEAR on clear_i. Sets sweep ptr=0 and busy_o=1 from the next cycle.
//   CLEAR: gnt=0. mem[ptr] <= 0 each cycle, then ptr++.
//    At ptr==NUM_WORDS-1, write it and go to IDLE; busy_o=0 the following cycle.
//    The sweep takes NUM_WORDS cycles. Responses already in the pipe still drain normally.
//    clear_i is ignored while in CLEAR.
//  clear_i with req in the same IDLE cycle: the request is granted and processed first,
//   and CLEAR starts on the next cycle. That write is later zeroed by the sweep.
//  Reset mid-sweep: returns to IDLE and drops the pipe. Unswept words keep old contents.
// TESTING
//  1 Write 0xCAFE_0001 to 0x1A10_0000 (be=F, aid=3), then read it.
//    -> gnt same cycle; rvalid LATENCY cycles later, rdata 0xCAFE_0001, rid 3, err 0.
//  2 Write 0xAABBCCDD, then write 0x11223344 with be=4'b0101, then read.
//    -> rdata 0xAA22CC44; wr_cnt_o=2, rd_cnt_o=1.
//  3 Read 0x1A10_0400 with NUM_WORDS=256 -> err=1, rdata DEAD_BEEF, counters unchanged.
//    Same for addr 0x1A0F_FFFC.
//  4 STALL_PERIOD=3 with req held for 9 cycles -> gnt pattern 1,1,0 repeated.
//    Exactly 6 hs, 6 rvalids in order with matching rid.
//  5 Fill 4 words, pulse clear_i -> busy_o high 256 cycles and req not granted meanwhile.
//    Afterwards all 4 reads return 0.
//  6 Assert rst_ni low at sweep ptr=10 -> busy_o=0 and rvalid=0 immediately.
//    Word 20 keeps its value and word 5 reads 0.

Source files
------------

// File: rtl/cnn_obi_spm.sv
// OBI subordinate scratchpad for the CNN accelerator manager port: fixed-latency
// responses, optional periodic grant stalls and a zeroing sweep between inference runs.
module cnn_obi_spm #(
    parameter int unsigned ID_WIDTH     = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h1A10_0000,
    parameter int unsigned NUM_WORDS    = 256,
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned STALL_PERIOD = 0,
    localparam int unsigned REQ_W       = 70 + ID_WIDTH,
    localparam int unsigned RSP_W       = 35 + ID_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    // {req, addr[31:0], we, be[3:0], wdata[31:0], aid[ID_WIDTH-1:0]}
    input  logic [REQ_W-1:0] sbr_obi_req_i,
    // {gnt, rvalid, rdata[31:0], rid[ID_WIDTH-1:0], err}
    output logic [RSP_W-1:0] sbr_obi_rsp_o,
    input  logic             clear_i,
    output logic             busy_o,
    output logic [15:0]      rd_cnt_o,
    output logic [15:0]      wr_cnt_o
);

    localparam int unsigned AW = $clog2(NUM_WORDS);
    localparam int unsigned SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [SW-1:0] STALL_LAST = (STALL_PERIOD > 0) ? SW'(STALL_PERIOD - 1) : '0;

    typedef enum logic {S_IDLE, S_CLEAR} state_e;

    logic                req;
    logic [31:0]         addr;
    logic                we;
    logic [3:0]          be;
    logic [31:0]         wdata;
    logic [ID_WIDTH-1:0] aid;

    assign {req, addr, we, be, wdata, aid} = sbr_obi_req_i;

    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;

    assign off      = addr - BASE_ADDR;
    assign in_range = (addr >= BASE_ADDR) && (off < 32'(NUM_WORDS * 4));
    assign idx      = off[AW+1:2];

    state_e              state_q;
    logic [AW-1:0]       ptr_q;
    logic                busy_q;
    logic [SW-1:0]       stall_q;
    logic [15:0]         rd_cnt_q;
    logic [15:0]         wr_cnt_q;
    logic                pv_q     [LATENCY];
    logic [ID_WIDTH-1:0] prid_q   [LATENCY];
    logic [31:0]         prdata_q [LATENCY];
    logic                perr_q   [LATENCY];
    logic [31:0]         mem_q    [NUM_WORDS];

    logic                stall;
    logic                gnt;
    logic                hs;
    logic [31:0]         s0_rdata_d;
    logic                s0_err_d;
    logic [ID_WIDTH-1:0] s0_rid_d;

    assign stall = (STALL_PERIOD != 0) && (stall_q == STALL_LAST);
    assign gnt   = req && (state_q == S_IDLE) && !stall;
    assign hs    = req && gnt;

    // Stage-0 payload is forced to zero whenever no handshake loads it.
    always_comb begin
        s0_rdata_d = '0;
        s0_err_d   = 1'b0;
        s0_rid_d   = '0;
        if (hs) begin
            s0_rid_d = aid;
            s0_err_d = !in_range;
            if (!we) begin
                s0_rdata_d = in_range ? mem_q[idx] : 32'hDEAD_BEEF;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            busy_q   <= 1'b0;
            stall_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pv_q[i]     <= 1'b0;
                prid_q[i]   <= '0;
                prdata_q[i] <= '0;
                perr_q[i]   <= 1'b0;
            end
        end else begin
            if (req && (state_q == S_IDLE)) begin
                stall_q <= stall ? '0 : stall_q + 1'b1;
            end

            if (hs && in_range && !we && (rd_cnt_q != '1)) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            if (hs && in_range && we && (wr_cnt_q != '1)) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end

            pv_q[0]     <= hs;
            prid_q[0]   <= s0_rid_d;
            prdata_q[0] <= s0_rdata_d;
            perr_q[0]   <= s0_err_d;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pv_q[i]     <= pv_q[i-1];
                prid_q[i]   <= prid_q[i-1];
                prdata_q[i] <= prdata_q[i-1];
                perr_q[i]   <= perr_q[i-1];
            end

            case (state_q)
                S_IDLE: begin
                    if (clear_i) begin
                        state_q <= S_CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == AW'(NUM_WORDS - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Array has no reset; sweep and handshake writes never coincide since gnt=0 in CLEAR.
    always_ff @(posedge clk_i) begin
        if (state_q == S_CLEAR) begin
            mem_q[ptr_q] <= '0;
        end else if (hs && we && in_range) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign sbr_obi_rsp_o = {gnt, pv_q[LATENCY-1], prdata_q[LATENCY-1],
                            prid_q[LATENCY-1], perr_q[LATENCY-1]};
    assign busy_o        = busy_q;
    assign rd_cnt_o      = rd_cnt_q;
    assign wr_cnt_o      = wr_cnt_q;

endmodule

// File: tb/tb_cnn_obi_spm.sv
// Randomised and directed bench for cnn_obi_spm, scored against a cycle-level reference
// model of the scratchpad (array, stall rule, sweep, response timing, counters).
module tb_cnn_obi_spm;

    localparam int unsigned IDW  = 4;
    localparam int unsigned NW   = 256;
    localparam int unsigned LAT  = 2;
    localparam int unsigned SP   = 3;
    localparam logic [31:0] BASE = 32'h1A10_0000;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic                clear = 1'b0;
    logic [70+IDW-1:0]   req_vec = '0;
    logic [35+IDW-1:0]   rsp_vec;
    logic                busy;
    logic [15:0]         rd_cnt;
    logic [15:0]         wr_cnt;

    logic                o_gnt, o_rvalid, o_err;
    logic [31:0]         o_rdata;
    logic [IDW-1:0]      o_rid;
    assign {o_gnt, o_rvalid, o_rdata, o_rid, o_err} = rsp_vec;

    cnn_obi_spm #(
        .ID_WIDTH    (IDW),
        .BASE_ADDR   (BASE),
        .NUM_WORDS   (NW),
        .LATENCY     (LAT),
        .STALL_PERIOD(SP)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .sbr_obi_req_i(req_vec),
        .sbr_obi_rsp_o(rsp_vec),
        .clear_i      (clear),
        .busy_o       (busy),
        .rd_cnt_o     (rd_cnt),
        .wr_cnt_o     (wr_cnt)
    );

    always #5 clk = ~clk;

    // Stimulus for the next cycle
    logic           d_req = 1'b0, d_we = 1'b0, d_clear = 1'b0;
    logic [31:0]    d_addr = '0, d_wdata = '0;
    logic [3:0]     d_be = '0;
    logic [IDW-1:0] d_aid = '0;

    // Reference model
    typedef struct {
        int             due;
        logic [IDW-1:0] rid;
        logic [31:0]    rdata;
        logic           err;
    } exp_rsp_t;

    logic [31:0] m_mem [NW];
    exp_rsp_t    m_q[$];
    bit          m_clr = 0;
    int          m_ptr = 0;
    int          m_reqcnt = 0;
    int          m_rd = 0, m_wr = 0;
    int          cyc = 0;

    int             n_checks = 0, n_fail = 0;
    logic [31:0]    last_rdata = '0;
    logic [IDW-1:0] last_rid = '0;
    logic           last_err = 1'b0;
    logic           last_gnt = 1'b0;
    int             n_rvalid = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        bit       stall, g, inr;
        int       idx;
        exp_rsp_t r;
        exp_rsp_t n;
        @(negedge clk);
        req_vec = {d_req, d_addr, d_we, d_be, d_wdata, d_aid};
        clear   = d_clear;
        #1;
        stall = (m_reqcnt % SP) == (SP - 1);
        g     = d_req && !m_clr && !stall;
        check("gnt", o_gnt, g);
        check("busy", busy, m_clr);
        check("rd_cnt", rd_cnt, m_rd);
        check("wr_cnt", wr_cnt, m_wr);
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            r = m_q.pop_front();
            check("rvalid", o_rvalid, 1);
            check("rdata", o_rdata, r.rdata);
            check("rid", o_rid, r.rid);
            check("err", o_err, r.err);
        end else begin
            check("rvalid_idle", o_rvalid, 0);
            check("rdata_idle", o_rdata, 0);
            check("rid_idle", o_rid, 0);
            check("err_idle", o_err, 0);
        end
        if (o_rvalid) begin
            last_rdata = o_rdata;
            last_rid   = o_rid;
            last_err   = o_err;
            n_rvalid++;
        end
        last_gnt = o_gnt;

        if (d_req && !m_clr) m_reqcnt++;
        if (g) begin
            inr   = (d_addr >= BASE) && ((d_addr - BASE) < NW * 4);
            idx   = inr ? int'((d_addr - BASE) >> 2) : 0;
            n.due = cyc + LAT;
            n.rid = d_aid;
            n.err = !inr;
            if (d_we) begin
                n.rdata = '0;
                if (inr) begin
                    for (int b = 0; b < 4; b++)
                        if (d_be[b]) m_mem[idx][8*b +: 8] = d_wdata[8*b +: 8];
                    if (m_wr < 65535) m_wr++;
                end
            end else begin
                n.rdata = inr ? m_mem[idx] : 32'hDEAD_BEEF;
                if (inr && m_rd < 65535) m_rd++;
            end
            m_q.push_back(n);
        end
        if (m_clr) begin
            m_mem[m_ptr] = '0;
            m_ptr++;
            if (m_ptr == NW) m_clr = 0;
        end else if (d_clear) begin
            m_clr = 1;
            m_ptr = 0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        d_req = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        d_req   = 1'b0;
        d_clear = 1'b0;
        req_vec = '0;
        clear   = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_rvalid", o_rvalid, 0);
        check("rst_gnt", o_gnt, 0);
        check("rst_rdata", o_rdata, 0);
        check("rst_rid", o_rid, 0);
        check("rst_err", o_err, 0);
        check("rst_rd_cnt", rd_cnt, 0);
        check("rst_wr_cnt", wr_cnt, 0);
        m_q.delete();
        m_clr = 0; m_reqcnt = 0; m_rd = 0; m_wr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(input bit we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input logic [IDW-1:0] aid);
        int n = 0;
        d_req = 1'b1; d_we = we; d_addr = addr; d_be = be; d_wdata = wd; d_aid = aid;
        do begin
            step();
            n++;
        end while (!last_gnt && n < 8);
        if (!last_gnt) check("gnt_timeout", last_gnt, 1);
        d_req = 1'b0;
    endtask

    function automatic logic [31:0] wa(input int i);
        return BASE + 32'(i * 4);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [8:0] pat;
        int         hs_cnt, rv0, busy_cnt, gnt_cnt;
        int         sel;

        do_reset();

        // Known array contents
        d_clear = 1'b1; step(); d_clear = 1'b0;
        idle(NW + 2);

        // Write then read word 0
        issue(1, BASE, 4'hF, 32'hCAFE_0001, 4'd3);
        issue(0, BASE, 4'hF, 32'h0, 4'd3);
        idle(LAT + 1);
        check("t1_rdata", last_rdata, 32'hCAFE_0001);
        check("t1_rid", last_rid, 3);
        check("t1_err", last_err, 0);

        // Byte enables and counters
        do_reset();
        issue(1, wa(1), 4'hF, 32'hAABB_CCDD, 4'd1);
        issue(1, wa(1), 4'b0101, 32'h1122_3344, 4'd2);
        issue(0, wa(1), 4'hF, 32'h0, 4'd4);
        idle(LAT + 1);
        check("t2_rdata", last_rdata, 32'hAA22_CC44);
        check("t2_wr_cnt", wr_cnt, 2);
        check("t2_rd_cnt", rd_cnt, 1);
        issue(1, wa(1), 4'h0, 32'hFFFF_FFFF, 4'd5);
        issue(0, wa(1), 4'hF, 32'h0, 4'd6);
        idle(LAT + 1);
        check("t2_be0_rdata", last_rdata, 32'hAA22_CC44);

        // Out of range on both sides of the window
        issue(0, 32'h1A10_0400, 4'hF, 32'h0, 4'd7);
        idle(LAT + 1);
        check("t3_hi_err", last_err, 1);
        check("t3_hi_rdata", last_rdata, 32'hDEAD_BEEF);
        issue(0, 32'h1A0F_FFFC, 4'hF, 32'h0, 4'd8);
        idle(LAT + 1);
        check("t3_lo_err", last_err, 1);
        check("t3_lo_rdata", last_rdata, 32'hDEAD_BEEF);
        issue(1, 32'h1A10_0400, 4'hF, 32'h1234_5678, 4'd9);
        idle(LAT + 1);
        check("t3_wr_err", last_err, 1);
        check("t3_wr_rdata", last_rdata, 0);
        check("t3_rd_cnt", rd_cnt, 2);
        check("t3_wr_cnt", wr_cnt, 3);

        // Periodic stall pattern
        do_reset();
        pat = '0; hs_cnt = 0; rv0 = n_rvalid;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF;
        for (int i = 0; i < 9; i++) begin
            d_addr = wa(i);
            d_aid  = IDW'(i);
            step();
            pat = {pat[7:0], last_gnt};
            if (last_gnt) hs_cnt++;
        end
        idle(LAT + 1);
        check("t4_gnt_pattern", pat, 9'b110_110_110);
        check("t4_hs_count", hs_cnt, 6);
        check("t4_rvalid_count", n_rvalid - rv0, 6);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            d_req   = ($urandom % 4) != 0;
            d_we    = $urandom % 2;
            d_be    = 4'($urandom);
            d_wdata = $urandom;
            d_aid   = IDW'($urandom);
            d_clear = ($urandom % 300) == 0;
            sel     = $urandom % 20;
            if (sel < 17)       d_addr = wa($urandom % 16) | 32'($urandom % 4);
            else if (sel == 17) d_addr = 32'h1A10_0400 + 32'($urandom % 64);
            else if (sel == 18) d_addr = 32'h1A0F_FFFC;
            else                d_addr = $urandom;
            step();
        end
        d_clear = 1'b0;
        idle(NW + LAT + 2);

        // Clear sweep with a request held throughout
        for (int i = 0; i < 4; i++) issue(1, wa(i), 4'hF, $urandom | 32'h1, IDW'(i));
        d_req = 1'b1; d_we = 1'b1; d_addr = wa(4); d_be = 4'hF; d_wdata = 32'h5A5A_5A5A;
        d_clear = 1'b1;
        step();
        d_clear = 1'b0; d_we = 1'b0; d_addr = wa(0);
        busy_cnt = 0; gnt_cnt = 0;
        repeat (NW) begin
            step();
            if (busy) busy_cnt++;
            if (last_gnt) gnt_cnt++;
        end
        idle(LAT + 2);
        check("t5_busy_cycles", busy_cnt, NW);
        check("t5_no_gnt", gnt_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            issue(0, wa(i), 4'hF, 32'h0, IDW'(i));
            idle(LAT + 1);
            check("t5_zero", last_rdata, 0);
        end

        // Reset in the middle of a sweep
        issue(1, wa(20), 4'hF, 32'h1234_5678, 4'd1);
        issue(1, wa(5), 4'hF, 32'h55AA_55AA, 4'd2);
        d_clear = 1'b1; step(); d_clear = 1'b0;
        idle(10);
        do_reset();
        issue(0, wa(5), 4'hF, 32'h0, 4'd3);
        idle(LAT + 1);
        check("t6_word5", last_rdata, 0);
        issue(0, wa(20), 4'hF, 32'h0, 4'd4);
        idle(LAT + 1);
        check("t6_word20", last_rdata, 32'h1234_5678);
        check("t6_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
